// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display multiplexer.
package display_pkg;

  typedef enum logic [1:0] {SHOW0, GAP0, SHOW1, GAP1} mux_state_t;

  localparam logic [1:0] AN_OFF = 2'b11;
  localparam logic [1:0] AN_D0  = 2'b10;
  localparam logic [1:0] AN_D1  = 2'b01;

  // Counter width able to hold max(a,b)-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase counter: counts up from zero, flags when it reaches the loaded terminal value.
module phase_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic [W-1:0] term_i,
  output logic         tc_c
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = clr_i ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc_c = (cnt_q == term_i);

endmodule

// File: rtl/display_mux_ctrl.sv
// Time-multiplexes two hex nibbles onto one decoder with active-low anode
// enables and an all-off blanking gap between digits.
module display_mux_ctrl
  import display_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 24000,
  parameter int unsigned BLANK_CYCLES = 480
) (
  input  logic       int_osc,
  input  logic       reset,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  output logic [3:0] hex_out,
  output logic [1:0] an,
  output logic       digit_sel,
  output logic       blank,
  output logic       frame
);

  localparam int unsigned CNT_W = cnt_width(DWELL_CYCLES, BLANK_CYCLES);
  localparam logic [CNT_W-1:0] DWELL_TERM = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_TERM = CNT_W'(BLANK_CYCLES - 1);

  mux_state_t       state_q, state_d;
  logic [3:0]       hex_q, hex_d;
  logic [1:0]       an_q, an_d;
  logic             sel_q, sel_d;
  logic             blank_q, blank_d;
  logic             frame_q, frame_d;
  logic [CNT_W-1:0] term_c;
  logic             tc_c;

  // Timer restarts on every transition, i.e. whenever it hits terminal count.
  phase_timer #(.W(CNT_W)) u_timer (
    .clk    (int_osc),
    .rst_n  (reset),
    .clr_i  (tc_c),
    .term_i (term_c),
    .tc_c   (tc_c)
  );

  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      state_q <= GAP1;
      hex_q   <= 4'h0;
      an_q    <= AN_OFF;
      sel_q   <= 1'b1;
      blank_q <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hex_q   <= hex_d;
      an_q    <= an_d;
      sel_q   <= sel_d;
      blank_q <= blank_d;
      frame_q <= frame_d;
    end
  end

  // Next state and next outputs; outputs only change on a transition edge.
  always_comb begin
    state_d = state_q;
    hex_d   = hex_q;
    an_d    = an_q;
    sel_d   = sel_q;
    blank_d = blank_q;
    frame_d = 1'b0;
    term_c  = BLANK_TERM;
    if (state_q == SHOW0 || state_q == SHOW1) term_c = DWELL_TERM;
    if (tc_c) begin
      unique case (state_q)
        SHOW0: begin
          state_d = GAP0;
          an_d    = AN_OFF;
          blank_d = 1'b1;
        end
        GAP0: begin
          state_d = SHOW1;
          an_d    = AN_D1;
          hex_d   = s1;
          sel_d   = 1'b1;
          blank_d = 1'b0;
        end
        SHOW1: begin
          state_d = GAP1;
          an_d    = AN_OFF;
          blank_d = 1'b1;
        end
        GAP1: begin
          state_d = SHOW0;
          an_d    = AN_D0;
          hex_d   = s0;
          sel_d   = 1'b0;
          blank_d = 1'b0;
          frame_d = 1'b1;
        end
        default: state_d = GAP1;
      endcase
    end
  end

  assign hex_out   = hex_q;
  assign an        = an_q;
  assign digit_sel = sel_q;
  assign blank     = blank_q;
  assign frame     = frame_q;

endmodule

// File: tb/tb_display_mux_ctrl.sv
// Bench for display_mux_ctrl: small-parameter instance against a frame-position
// model, plus a default-parameter instance for absolute timing.
module tb_display_mux_ctrl;

  localparam int D = 4;
  localparam int B = 2;
  localparam int P = 2 * (D + B);

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] s0, s1;
  logic [3:0] hex_out;
  logic [1:0] an;
  logic       digit_sel, blank, frame;

  logic       rst_d;
  logic [3:0] ds0, ds1;
  logic [3:0] dhex;
  logic [1:0] dan;
  logic       dsel, dblank, dframe;

  display_mux_ctrl #(.DWELL_CYCLES(D), .BLANK_CYCLES(B)) u_dut (
    .int_osc(clk), .reset(rst_n), .s0(s0), .s1(s1),
    .hex_out(hex_out), .an(an), .digit_sel(digit_sel), .blank(blank), .frame(frame)
  );

  display_mux_ctrl u_def (
    .int_osc(clk), .reset(rst_d), .s0(ds0), .s1(ds1),
    .hex_out(dhex), .an(dan), .digit_sel(dsel), .blank(dblank), .frame(dframe)
  );

  int total = 0;
  int bad   = 0;
  logic def_done = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: e = rising edges since reset release; frame position follows from e.
  int         e = 0;
  logic [3:0] m_hex = 4'h0;
  logic       m_sel = 1'b1;

  function automatic int phase();
    return (e - B) % P;
  endfunction

  function automatic logic [1:0] exp_an();
    int p;
    if (e < B) return 2'b11;
    p = phase();
    if (p < D)         return 2'b10;
    if (p < D + B)     return 2'b11;
    if (p < 2 * D + B) return 2'b01;
    return 2'b11;
  endfunction

  function automatic logic exp_frame();
    return (e >= B) && (phase() == 0);
  endfunction

  task automatic model_reset();
    e = 0; m_hex = 4'h0; m_sel = 1'b1;
  endtask

  task automatic model_edge();
    if (!rst_n) model_reset();
    else begin
      e++;
      if (e >= B) begin
        if (phase() == 0)          begin m_hex = s0; m_sel = 1'b0; end
        else if (phase() == D + B) begin m_hex = s1; m_sel = 1'b1; end
      end
    end
  endtask

  task automatic check_all();
    check_eq("an", an, exp_an());
    check_eq("hex", hex_out, m_hex);
    check_eq("digit_sel", digit_sel, m_sel);
    check_eq("blank", blank, exp_an() == 2'b11);
    check_eq("frame", frame, exp_frame());
    check_eq("an_never_00", an == 2'b00, 0);
    check_eq("blank_iff_off", blank, an == 2'b11);
    check_eq("frame_only_d0", frame && (an != 2'b10), 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; s0 = 4'h3; s1 = 4'hA;
    repeat (3) step();
    @(negedge clk) rst_n = 1'b1;
    step(); step();
    check_eq("t1_an", an, 2'b10);
    check_eq("t1_hex", hex_out, 4'h3);
    check_eq("t1_frame", frame, 1'b1);

    repeat (3 * P) step();

    // Change s0 in the second cycle of SHOW0.
    for (int i = 0; i < 2 * P && !(e >= B && phase() == 1); i++) step();
    s0 = 4'h7;
    repeat (P) step();

    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(7) == 0) s0 = 4'($urandom);
      if ($urandom_range(7) == 0) s1 = 4'($urandom);
      step();
      if (i == 5000) begin
        for (int k = 0; k < 2 * P && !(e >= B && phase() > D + B); k++) step();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("arst_an", an, 2'b11);
        check_eq("arst_hex", hex_out, 4'h0);
        check_all();
        step();
        rst_n = 1'b1;
        step(); step();
        check_eq("resume_an", an, 2'b10);
        check_eq("resume_frame", frame, 1'b1);
      end
    end

    for (int i = 0; i < 60000 && !def_done; i++) @(negedge clk);
    check_eq("def_timeout", def_done, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Default-parameter timing: first frame, dwell, gap and frame period.
  initial begin
    int c, fr1, g0, sh1, fr2;
    rst_d = 1'b0; ds0 = 4'h5; ds1 = 4'h9;
    c = 0; fr1 = -1; g0 = -1; sh1 = -1; fr2 = -1;
    repeat (2) @(negedge clk);
    rst_d = 1'b1;
    while (c < 60000 && fr2 < 0) begin
      @(negedge clk);
      c++;
      if (dframe) begin
        if (fr1 < 0) begin
          fr1 = c;
          check_eq("def_first_hex", dhex, 4'h5);
        end else fr2 = c;
      end
      if (fr1 >= 0 && g0 < 0 && dan == 2'b11) g0 = c;
      if (g0 >= 0 && sh1 < 0 && dan == 2'b01) begin
        sh1 = c;
        check_eq("def_d1_hex", dhex, 4'h9);
      end
    end
    check_eq("def_first_frame", fr1, 480);
    check_eq("def_dwell", g0 - fr1, 24000);
    check_eq("def_gap", sh1 - g0, 480);
    check_eq("def_period", fr2 - fr1, 48960);
    def_done = 1'b1;
  end

endmodule
